// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit; the instruction decoder
// imports the same op encodings.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide on operand magnitudes, with signs applied in a final cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t state, state_nxt;

    // acc holds {upper, multiplier} for multiply and {rem, quot} for divide
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic               is_div, neg_res, neg_rem, dz_pend;

    logic               op_signed, op_div, start_dz;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem_sh, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign start_dz  = op_div && (B == '0);
    assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    assign div_rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, mcand};
    assign div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_s = neg_res ? -acc : acc;
    assign quot_s = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_s  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Divide-by-zero bypasses RUN and reports from SIGN one edge after start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = start_dz ? SIGN : RUN;
            RUN:     if (count == '0) state_nxt = SIGN;
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_zero <= 1'b0;
                        count    <= CW'(WIDTH - 1);
                        is_div   <= op_div;
                        dz_pend  <= start_dz;
                        neg_res  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem  <= op_signed && op_div && A[WIDTH-1];
                        mcand    <= op_div ? b_mag : a_mag;
                        // raw dividend is kept for the divide-by-zero HI value
                        acc      <= {{WIDTH{1'b0}}, op_div ? (start_dz ? A : a_mag) : b_mag};
                    end else begin
                        if (mthi) hi <= A;
                        if (mtlo) lo <= A;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    if (count != '0) count <= count - 1'b1;
                end
                SIGN: begin
                    done <= 1'b1;
                    if (dz_pend) begin
                        hi       <= acc[WIDTH-1:0];
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_s;
                        lo <= quot_s;
                    end else begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops compared
// against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk, rst_n, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // HI/LO semantics straight from the instruction definitions
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint          sa, sb, p, q, r;
        longint unsigned up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin up = {32'h0, a} * {32'h0, b}; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    dz = 1'b1; h = a; l = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
                end else begin
                    uq = {32'h0, a} / {32'h0, b}; ur = {32'h0, a} % {32'h0, b};
                    h = ur[31:0]; l = uq[31:0];
                end
            end
        endcase
    endfunction

    // inject: 0 none, 1 stray start mid-op, 2 mthi mid-op, 3 mthi/mtlo alongside start
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int inject);
        logic [31:0] ehi, elo;
        logic        edz;
        int          lat, explat;
        model(o, a, b, ehi, elo, edz);
        explat = edz ? 1 : 33;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        if (inject == 3) begin mthi = 1'b1; mtlo = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checkOutput("busy_e0", busy, 1);
        checkOutput("done_e0", done, 0);
        checkOutput("dz_clear", div_zero, 0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            if (k == 9 && inject == 1) begin start = 1'b1; op = OP_MULTU; A = 32'h1; B = 32'h1; end
            if (k == 9 && inject == 2) begin mthi = 1'b1; A = 32'hDEAD_BEEF; end
            if (k == 10) begin start = 1'b0; mthi = 1'b0; end
            if (k == 12) begin
                checkOutput("hold_hi", hi, exp_hi);
                checkOutput("hold_lo", lo, exp_lo);
                checkOutput("busy_run", busy, 1);
            end
        end
        checkOutput("latency", lat, explat);
        checkOutput("hi", hi, ehi);
        checkOutput("lo", lo, elo);
        checkOutput("div_zero", div_zero, {31'h0, edz});
        checkOutput("busy_done", busy, 0);
        exp_hi = ehi;
        exp_lo = elo;
        @(posedge clk); #1;
        checkOutput("done_pulse", done, 0);
        checkOutput("dz_held", div_zero, {31'h0, edz});
    endtask

    task automatic moveHiLo(input logic h_en, input logic l_en, input logic [31:0] a);
        @(negedge clk);
        mthi = h_en; mtlo = l_en; A = a;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (h_en) exp_hi = a;
        if (l_en) exp_lo = a;
        checkOutput("move_hi", hi, exp_hi);
        checkOutput("move_lo", lo, exp_lo);
        checkOutput("move_busy", busy, 0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;
        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = OP_MULT; A = '0; B = '0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dz", div_zero, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        @(negedge clk); rst_n = 1'b1;

        applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'h7, 0);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        moveHiLo(1'b1, 1'b0, 32'hAAAA_0000);
        moveHiLo(1'b0, 1'b1, 32'h0000_5555);
        applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 2);
        moveHiLo(1'b1, 1'b1, 32'h1357_9BDF);
        applyStimulus(OP_MULT,  32'h9, 32'h3, 3);
        applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'h2, 0);
        applyStimulus(OP_DIVU,  32'd100, 32'd7, 0);
        applyStimulus(OP_DIV,   32'h1234_5678, 32'h0, 0);
        applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(OP_DIVU,  32'hFFFF_FFFF, 32'h0, 0);
        applyStimulus(OP_DIVU,  32'hFFFF_FFFF, 32'h1, 0);

        for (int n = 0; n < 40; n++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) rb = 32'($urandom_range(1, 15));
            if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            applyStimulus(ro, ra, rb, 0);
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        op = OP_MULT; A = 32'd5; B = 32'd6; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_hi", hi, 0);
        checkOutput("mid_rst_lo", lo, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk); rst_n = 1'b1;
        applyStimulus(OP_MULT, 32'd5, 32'd6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
